// File: rtl/puf_auth_pkg.sv
// Shared types and constants for the PUF authentication sequencer.
package puf_auth_pkg;

    localparam int unsigned CntW     = 16;
    localparam int unsigned WdMargin = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDone,
        StLocked
    } state_e;

endpackage

// File: rtl/puf_sig_capture.sv
// PUF response signature register: clear, shift-in at the LSB, compare to golden.
module puf_sig_capture #(
    parameter int unsigned SIG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic [SIG_W-1:0] golden_i,
    output logic [SIG_W-1:0] sig_o,
    output logic             match_o
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (shift_i) begin
            sig_d = {sig_q[SIG_W-2:0], bit_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o   = sig_q;
    assign match_o = (sig_q == golden_i);

endmodule

// File: rtl/puf_auth_sequencer.sv
// PUF authentication sequencer: drives the scan-enable counter, captures and checks
// the response. Define PUF_AUTH_LOCKOUT_EN to lock out after MAX_FAIL consecutive failures.
module puf_auth_sequencer
    import puf_auth_pkg::*;
#(
    parameter int unsigned SIG_W    = 32,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_n_auth,
    input  logic [15:0]      req_l_scan,
    input  logic [SIG_W-1:0] req_golden,
    input  logic             abort,
    output logic [15:0]      cnt_n_auth,
    output logic [15:0]      cnt_l_scan,
    output logic             cnt_start,
    input  logic             se_signal,
    input  logic             scan_in,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic             locked,
    output logic [3:0]       fail_cnt
);

    localparam logic [3:0]    MaxFail = 4'(MAX_FAIL);
    localparam logic [CntW:0] WdAdd   = (CntW + 1)'(WdMargin);
    localparam logic [CntW:0] WdOne   = {{CntW{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CntW-1:0]  n_q, n_d, l_q, l_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [CntW:0]    wd_q, wd_d;
    logic             seen_q, seen_d;
    logic             pass_q, pass_d, err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    logic             sig_clear, sig_shift, sig_match;
    logic [SIG_W-1:0] sig_val;
    logic [CntW:0]    req_sum, wd_limit, wd_inc;
    logic             req_bad;
    logic [3:0]       fail_inc;

    puf_sig_capture #(
        .SIG_W (SIG_W)
    ) u_sig_capture (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (sig_clear),
        .shift_i  (sig_shift),
        .bit_i    (scan_in),
        .golden_i (golden_q),
        .sig_o    (sig_val),
        .match_o  (sig_match)
    );

    // A window that overflows 16 bits cannot be produced by the counter, so reject it.
    assign req_sum  = {1'b0, req_n_auth} + {1'b0, req_l_scan};
    assign req_bad  = (req_l_scan == '0) || req_sum[CntW];
    assign wd_limit = {1'b0, n_q} + {1'b0, l_q} + WdAdd;
    assign wd_inc   = wd_q + WdOne;
    assign fail_inc = (fail_q < MaxFail) ? fail_q + 4'd1 : fail_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        l_d       = l_q;
        golden_d  = golden_q;
        wd_d      = wd_q;
        seen_d    = seen_q;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;
        sig_clear = 1'b0;
        sig_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    n_d      = req_n_auth;
                    l_d      = req_l_scan;
                    golden_d = req_golden;
                    if (req_bad) begin
                        state_d = StDone;
                        pass_d  = 1'b0;
                        err_d   = 1'b1;
                        fail_d  = fail_inc;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                sig_clear = 1'b1;
                wd_d      = '0;
                seen_d    = 1'b0;
                state_d   = abort ? StIdle : StRun;
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    wd_d = wd_inc;
                    if (!se_signal) begin
                        sig_shift = 1'b1;
                        seen_d    = 1'b1;
                    end
                    // A completed scan takes precedence over a coincident timeout.
                    if (se_signal && seen_q) begin
                        state_d = StDone;
                        pass_d  = sig_match;
                        err_d   = 1'b0;
                        fail_d  = sig_match ? 4'd0 : fail_inc;
                    end else if (wd_inc == wd_limit) begin
                        state_d = StDone;
                        pass_d  = 1'b0;
                        err_d   = 1'b1;
                        fail_d  = fail_inc;
                    end
                end
            end
            StDone: begin
`ifdef PUF_AUTH_LOCKOUT_EN
                state_d = (fail_q == MaxFail) ? StLocked : StIdle;
`else
                state_d = StIdle;
`endif
            end
            StLocked: begin
                state_d = StLocked;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            n_q      <= '0;
            l_q      <= '0;
            golden_q <= '0;
            wd_q     <= '0;
            seen_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            l_q      <= l_d;
            golden_q <= golden_d;
            wd_q     <= wd_d;
            seen_q   <= seen_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    // Outputs decode straight from state so a reset drops them without waiting for a clock.
    assign req_ready  = (state_q == StIdle);
    assign cnt_start  = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign pass       = done & pass_q;
    assign err        = done & err_q;
    assign cnt_n_auth = n_q;
    assign cnt_l_scan = l_q;
    assign fail_cnt   = fail_q;

`ifdef PUF_AUTH_LOCKOUT_EN
    assign locked = (state_q == StLocked);
`else
    assign locked = 1'b0;
`endif

endmodule

// File: doc/puf_auth_sequencer.md
PUF_AUTH_SEQUENCER -- requirements
Module: puf_auth_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SIG_W, 32, response signature width in bits (8..64).
  MAX_FAIL, 3, consecutive failures before lockout (1..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  req_valid  in  1  authentication request.
  req_ready  out  1  high only in IDLE and not locked.
  req_n_auth  in  16  authentication cycle count.
  req_l_scan  in  16  scan window length.
  req_golden  in  SIG_W  expected signature.
  abort  in  1  cancel the run in progress.
  cnt_n_auth  out  16  to scan-enable counter.
  cnt_l_scan  out  16  to scan-enable counter.
  cnt_start  out  1  counter enable; held for the whole run.
  se_signal  in  1  counter scan-enable (low = scan window).
  scan_in  in  1  PUF response bit.
  done  out  1  one-cycle result strobe.
  pass  out  1  result; valid while done=1.
  err  out  1  malformed request or timeout; valid while done=1.
  locked  out  1  lockout active.
  fail_cnt  out  4  consecutive failure count.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN, DONE and LOCKED.
REQ-004 Accept occurs when req_valid && req_ready; n_auth, l_scan and golden SHALL be latched and IDLE->LOAD.
REQ-005 On accept, if req_l_scan==0 or req_n_auth+req_l_scan>16'hFFFF (17-bit sum), the FSM SHALL go directly to DONE with err=1, pass=0, and the counter SHALL not start.
REQ-006 LOAD SHALL last exactly 1 cycle with cnt_n_auth/cnt_l_scan driven from latched values (held stable until next accept), then go to RUN.
REQ-007 In RUN, cnt_start=1; each cycle with se_signal==0 SHALL shift scan_in into signature LSB (shift left, keep low SIG_W bits) and set seen_low.
REQ-008 In RUN, se_signal==1 with seen_low set SHALL go to DONE next cycle; the signature SHALL be compared with golden: pass=(sig==golden), err=0.
REQ-009 If l_scan<SIG_W, unfilled upper signature bits SHALL be 0 (signature cleared in LOAD).
REQ-010 A 17-bit watchdog SHALL count RUN cycles; reaching n_auth+l_scan+4 SHALL force DONE with err=1, pass=0.
REQ-011 DONE SHALL last 1 cycle: done=1, cnt_start=0, then IDLE, or LOCKED if lockout triggers.
REQ-012 pass=1 SHALL clear fail_cnt; pass=0 (including err) SHALL increment fail_cnt, saturating at MAX_FAIL.
REQ-013 abort in LOAD or RUN SHALL go to IDLE next cycle, with cnt_start=0, no done, and fail_cnt unchanged; abort SHALL win over same-cycle completion or timeout.
REQ-014 abort in IDLE, DONE or LOCKED SHALL be ignored.
REQ-015 Latency SHALL be: accept at cycle T, cnt_start first high at T+2, done at the cycle after the first RUN cycle in which se_signal==1 follows the scan window.

Reset
REQ-016 rst SHALL force IDLE, req_ready=1, cnt_start=0, cnt_n_auth=0, cnt_l_scan=0, done=0, pass=0, err=0, locked=0, fail_cnt=0, signature=0, watchdog=0, seen_low=0.
REQ-017 rst asserted mid-run SHALL drop cnt_start immediately (asynchronously) and SHALL emit no done.

Configuration
REQ-018 With PUF_AUTH_LOCKOUT_EN defined, fail_cnt reaching MAX_FAIL in DONE SHALL enter LOCKED: locked=1, req_ready=0, exit only by rst.
REQ-019 Without PUF_AUTH_LOCKOUT_EN, LOCKED SHALL be unreachable, locked SHALL be tied to 0, and fail_cnt SHALL still saturate.

Structure
REQ-020 Package puf_auth_pkg SHALL hold the state enum, the 16-bit count width constant, and the watchdog margin constant (4).
REQ-021 Sub-module puf_sig_capture SHALL implement the clear/shift/compare of REQ-007..009.

Verification
REQ-022 n_auth=5, l_scan=8, golden=0x000000A5, scan_in bits 1,0,1,0,0,1,0,1 -> done at the expected cycle (REQ-015), pass=1, fail_cnt=0.
REQ-023 n_auth=16'hFFF0, l_scan=16'h0020 -> done 1 cycle after LOAD-less path, err=1, cnt_start never high.
REQ-024 se_signal stuck at 1 with n_auth=3, l_scan=4 -> done at RUN cycle 11, err=1, fail_cnt=1.
REQ-025 abort in the same cycle that se_signal returns high -> IDLE, no done pulse, fail_cnt unchanged.
REQ-026 Three mismatching runs with PUF_AUTH_LOCKOUT_EN defined -> locked=1, req_ready=0, then rst -> locked=0, fail_cnt=0; without the macro -> locked=0, fail_cnt=3.
